// File: rtl/test_traditional_pkg.sv
// Shared definitions for the traditional two-lane byte reader/packer.
package test_traditional_pkg;

    localparam int DEFAULT_WORD_BYTES = 4;
    localparam int BYTE_W             = 8;
    localparam int COUNT_W            = 16;

    // COLLECT: gathering bytes; STALL: a full word is parked behind a busy output.
    typedef enum logic {
        COLLECT = 1'b0,
        STALL   = 1'b1
    } state_e;

    // Result of arbitrating the two input lanes for one cycle.
    typedef struct packed {
        logic              accept;
        logic              collide;
        logic [BYTE_W-1:0] data;
    } lane_sel_t;

endpackage

// File: rtl/test_traditional_reader.sv
// Packs bytes from a registered lane and a combinational lane into
// little-endian words, with a one-deep output register, stall handling,
// sticky overflow and a delivered-word counter.
module test_traditional_reader
    import test_traditional_pkg::*;
#(
    parameter int WORD_BYTES = DEFAULT_WORD_BYTES
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [BYTE_W-1:0]               reg_data,
    input  logic                            reg_enable,
    input  logic [BYTE_W-1:0]               wire_data,
    input  logic                            wire_enable,
    input  logic                            flush,
    input  logic                            word_ready,
    output logic [BYTE_W*WORD_BYTES-1:0]    word_out,
    output logic                            word_valid,
    output logic [$clog2(WORD_BYTES):0]     fill_level,
    output logic                            overflow,
    output logic [COUNT_W-1:0]              word_count
);

    localparam int WORD_W = BYTE_W * WORD_BYTES;
    localparam int FILL_W = $clog2(WORD_BYTES) + 1;
    localparam logic [FILL_W-1:0] FILL_LAST = FILL_W'(WORD_BYTES - 1);
    localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(WORD_BYTES);

    // Registered lane has priority; a simultaneous wire byte is a collision.
    function automatic lane_sel_t select_lane(
        input logic              re,
        input logic [BYTE_W-1:0] rd,
        input logic              we,
        input logic [BYTE_W-1:0] wd
    );
        lane_sel_t s;
        s.accept  = re | we;
        s.collide = re & we;
        if (re) begin
            s.data = rd;
        end else begin
            s.data = wd;
        end
        return s;
    endfunction

    state_e              state_q,    state_d;
    logic [FILL_W-1:0]   fill_q,     fill_d;
    logic [WORD_W-1:0]   buf_q,      buf_d;
    logic [WORD_W-1:0]   word_out_q, word_out_d;
    logic                valid_q,    valid_d;
    logic                ovf_q,      ovf_d;
    logic [COUNT_W-1:0]  count_q,    count_d;

    lane_sel_t           lane_s;
    logic                handshake_s;
    logic                out_free_s;

    // Next-state logic: handshake bookkeeping first, then flush or per-state packing.
    always_comb begin
        state_d     = state_q;
        fill_d      = fill_q;
        buf_d       = buf_q;
        word_out_d  = word_out_q;
        valid_d     = valid_q;
        ovf_d       = ovf_q;
        count_d     = count_q;

        lane_s      = select_lane(reg_enable, reg_data, wire_enable, wire_data);
        handshake_s = valid_q & word_ready;
        out_free_s  = ~valid_q | word_ready;

        if (handshake_s) begin
            valid_d = 1'b0;
            count_d = count_q + 16'd1;
        end else begin
            count_d = count_q;
        end

        if (flush) begin
            // Partial word / parked word and the overflow flag are discarded;
            // the output register and counter only follow the handshake above.
            fill_d  = '0;
            state_d = COLLECT;
            ovf_d   = 1'b0;
        end else begin
            case (state_q)
                COLLECT: begin
                    if (lane_s.accept) begin
                        if (lane_s.collide) begin
                            ovf_d = 1'b1;
                        end else begin
                            ovf_d = ovf_q;
                        end
                        buf_d[BYTE_W*int'(fill_q) +: BYTE_W] = lane_s.data;
                        if (fill_q == FILL_LAST) begin
                            if (out_free_s) begin
                                word_out_d = buf_d;
                                valid_d    = 1'b1;
                                fill_d     = '0;
                            end else begin
                                state_d = STALL;
                                fill_d  = FILL_FULL;
                            end
                        end else begin
                            fill_d = fill_q + FILL_W'(1);
                        end
                    end else begin
                        fill_d = fill_q;
                    end
                end
                STALL: begin
                    // Output register is necessarily occupied here, so word_ready
                    // alone means the parked word can move up.
                    if (lane_s.accept) begin
                        ovf_d = 1'b1;
                    end else begin
                        ovf_d = ovf_q;
                    end
                    if (word_ready) begin
                        word_out_d = buf_q;
                        valid_d    = 1'b1;
                        fill_d     = '0;
                        state_d    = COLLECT;
                    end else begin
                        state_d = STALL;
                    end
                end
                default: begin
                    state_d = COLLECT;
                    fill_d  = '0;
                end
            endcase
        end
    end

    // State and output registers with asynchronous reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= COLLECT;
            fill_q     <= '0;
            buf_q      <= '0;
            word_out_q <= '0;
            valid_q    <= 1'b0;
            ovf_q      <= 1'b0;
            count_q    <= '0;
        end else begin
            state_q    <= state_d;
            fill_q     <= fill_d;
            buf_q      <= buf_d;
            word_out_q <= word_out_d;
            valid_q    <= valid_d;
            ovf_q      <= ovf_d;
            count_q    <= count_d;
        end
    end

    assign word_out   = word_out_q;
    assign word_valid = valid_q;
    assign fill_level = fill_q;
    assign overflow   = ovf_q;
    assign word_count = count_q;

endmodule

// File: tb/tb_test_traditional_reader.sv
// Directed bench for test_traditional_reader (WORD_BYTES = 4).
module tb_test_traditional_reader;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [7:0]  reg_data = 8'h00;
    logic        reg_enable = 1'b0;
    logic [7:0]  wire_data = 8'h00;
    logic        wire_enable = 1'b0;
    logic        flush = 1'b0;
    logic        word_ready = 1'b0;
    logic [31:0] word_out;
    logic        word_valid;
    logic [2:0]  fill_level;
    logic        overflow;
    logic [15:0] word_count;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    test_traditional_reader #(.WORD_BYTES(4)) dut (
        .clk         (clk),
        .reset       (reset),
        .reg_data    (reg_data),
        .reg_enable  (reg_enable),
        .wire_data   (wire_data),
        .wire_enable (wire_enable),
        .flush       (flush),
        .word_ready  (word_ready),
        .word_out    (word_out),
        .word_valid  (word_valid),
        .fill_level  (fill_level),
        .overflow    (overflow),
        .word_count  (word_count)
    );

    typedef struct {
        logic        re;
        logic [7:0]  rd;
        logic        we;
        logic [7:0]  wd;
        logic        fl;
        logic        rdy;
        logic [31:0] e_out;
        logic        e_valid;
        logic [2:0]  e_fill;
        logic        e_ovf;
        logic [15:0] e_cnt;
    } vec_t;

    vec_t vecs[12];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [31:0] e_out, input logic e_valid,
                           input logic [2:0] e_fill, input logic e_ovf, input logic [15:0] e_cnt);
        chk({tag, ".word_out"},   64'(word_out),   64'(e_out));
        chk({tag, ".word_valid"}, 64'(word_valid), 64'(e_valid));
        chk({tag, ".fill_level"}, 64'(fill_level), 64'(e_fill));
        chk({tag, ".overflow"},   64'(overflow),   64'(e_ovf));
        chk({tag, ".word_count"}, 64'(word_count), 64'(e_cnt));
    endtask

    // Drive one cycle of inputs (called #1 after a rising edge), then land #1 after the next edge.
    task automatic step(input logic re, input logic [7:0] rd, input logic we, input logic [7:0] wd,
                        input logic fl, input logic rdy);
        reg_enable  = re;
        reg_data    = rd;
        wire_enable = we;
        wire_data   = wd;
        flush       = fl;
        word_ready  = rdy;
        @(posedge clk);
        #1;
    endtask

    task automatic byte_in(input logic [7:0] b, input logic rdy);
        step(1'b1, b, 1'b0, 8'h00, 1'b0, rdy);
    endtask

    task automatic idle(input logic rdy);
        step(1'b0, 8'h00, 1'b0, 8'h00, 1'b0, rdy);
    endtask

    initial begin
        //          re    rd     we    wd     fl    rdy   out           v     fill  ovf   cnt
        vecs[0]  = '{1'b1, 8'h11, 1'b0, 8'h00, 1'b0, 1'b1, 32'h00000000, 1'b0, 3'd1, 1'b0, 16'd0};
        vecs[1]  = '{1'b1, 8'h22, 1'b0, 8'h00, 1'b0, 1'b1, 32'h00000000, 1'b0, 3'd2, 1'b0, 16'd0};
        vecs[2]  = '{1'b1, 8'h33, 1'b0, 8'h00, 1'b0, 1'b1, 32'h00000000, 1'b0, 3'd3, 1'b0, 16'd0};
        vecs[3]  = '{1'b1, 8'h44, 1'b0, 8'h00, 1'b0, 1'b1, 32'h44332211, 1'b1, 3'd0, 1'b0, 16'd0};
        vecs[4]  = '{1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b1, 32'h44332211, 1'b0, 3'd0, 1'b0, 16'd1};
        vecs[5]  = '{1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b1, 32'h44332211, 1'b0, 3'd0, 1'b0, 16'd1};
        vecs[6]  = '{1'b1, 8'hAA, 1'b1, 8'hBB, 1'b0, 1'b1, 32'h44332211, 1'b0, 3'd1, 1'b1, 16'd1};
        vecs[7]  = '{1'b0, 8'h00, 1'b1, 8'hCC, 1'b0, 1'b1, 32'h44332211, 1'b0, 3'd2, 1'b1, 16'd1};
        vecs[8]  = '{1'b1, 8'hDD, 1'b0, 8'h00, 1'b0, 1'b1, 32'h44332211, 1'b0, 3'd3, 1'b1, 16'd1};
        vecs[9]  = '{1'b1, 8'hEE, 1'b0, 8'h00, 1'b0, 1'b1, 32'hEEDDCCAA, 1'b1, 3'd0, 1'b1, 16'd1};
        vecs[10] = '{1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b1, 32'hEEDDCCAA, 1'b0, 3'd0, 1'b1, 16'd2};
        vecs[11] = '{1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b1, 32'hEEDDCCAA, 1'b0, 3'd0, 1'b0, 16'd2};

        // Reset state.
        @(posedge clk);
        @(posedge clk);
        #1;
        chk_all("reset", 32'h0, 1'b0, 3'd0, 1'b0, 16'd0);
        reset = 1'b0;

        // Table-driven single-cycle vectors.
        for (int i = 0; i < 12; i++) begin
            step(vecs[i].re, vecs[i].rd, vecs[i].we, vecs[i].wd, vecs[i].fl, vecs[i].rdy);
            chk_all($sformatf("vec%0d", i), vecs[i].e_out, vecs[i].e_valid,
                    vecs[i].e_fill, vecs[i].e_ovf, vecs[i].e_cnt);
        end

        // Back-pressure: two words with ready low, third byte dropped in STALL.
        byte_in(8'h01, 1'b0);
        byte_in(8'h02, 1'b0);
        byte_in(8'h03, 1'b0);
        byte_in(8'h04, 1'b0);
        chk_all("stall.w1", 32'h04030201, 1'b1, 3'd0, 1'b0, 16'd2);
        byte_in(8'h05, 1'b0);
        byte_in(8'h06, 1'b0);
        byte_in(8'h07, 1'b0);
        byte_in(8'h08, 1'b0);
        chk_all("stall.w2", 32'h04030201, 1'b1, 3'd4, 1'b0, 16'd2);
        byte_in(8'h09, 1'b0);
        chk_all("stall.drop", 32'h04030201, 1'b1, 3'd4, 1'b1, 16'd2);
        idle(1'b1);
        chk_all("stall.rel1", 32'h08070605, 1'b1, 3'd0, 1'b1, 16'd3);
        idle(1'b1);
        chk_all("stall.rel2", 32'h08070605, 1'b0, 3'd0, 1'b1, 16'd4);

        // Flush with a same-cycle wire byte.
        byte_in(8'h01, 1'b1);
        byte_in(8'h02, 1'b1);
        chk("flush.pre_fill", 64'(fill_level), 64'd2);
        step(1'b0, 8'h00, 1'b1, 8'h03, 1'b1, 1'b1);
        chk_all("flush", 32'h08070605, 1'b0, 3'd0, 1'b0, 16'd4);
        byte_in(8'h05, 1'b1);
        byte_in(8'h06, 1'b1);
        byte_in(8'h07, 1'b1);
        byte_in(8'h08, 1'b1);
        chk_all("flush.word", 32'h08070605, 1'b1, 3'd0, 1'b0, 16'd4);
        idle(1'b1);
        chk_all("flush.hs", 32'h08070605, 1'b0, 3'd0, 1'b0, 16'd5);

        // Asynchronous reset mid-word with a word held in the output register.
        byte_in(8'hA1, 1'b0);
        byte_in(8'hA2, 1'b0);
        byte_in(8'hA3, 1'b0);
        byte_in(8'hA4, 1'b0);
        byte_in(8'hB1, 1'b0);
        byte_in(8'hB2, 1'b0);
        byte_in(8'hB3, 1'b0);
        chk_all("prerst", 32'hA4A3A2A1, 1'b1, 3'd3, 1'b0, 16'd5);
        #3;
        reset = 1'b1;
        #1;
        chk_all("async_rst", 32'h0, 1'b0, 3'd0, 1'b0, 16'd0);
        step(1'b1, 8'hFF, 1'b1, 8'hEE, 1'b0, 1'b1);
        chk_all("rst_hold", 32'h0, 1'b0, 3'd0, 1'b0, 16'd0);
        reset = 1'b0;
        byte_in(8'hC1, 1'b0);
        byte_in(8'hC2, 1'b0);
        byte_in(8'hC3, 1'b0);
        byte_in(8'hC4, 1'b0);
        chk_all("post_rst", 32'hC4C3C2C1, 1'b1, 3'd0, 1'b0, 16'd0);

        // Counter wrap: preset to 0xFFFF, then one handshake.
        force dut.count_q = 16'hFFFF;
        #1;
        release dut.count_q;
        idle(1'b1);
        chk("wrap.count", 64'(word_count), 64'h0);
        chk("wrap.valid", 64'(word_valid), 64'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/test_traditional_reader.md
TEST_TRADITIONAL_READER -- requirements
Module: test_traditional_reader

Interface
REQ-001 WORD_BYTES, 4, bytes packed per output word; legal values 2..8.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 reg_data  input  8  byte from the registered lane.
REQ-005 reg_enable  input  1  reg_data valid this cycle.
REQ-006 wire_data  input  8  byte from the combinational lane.
REQ-007 wire_enable  input  1  wire_data valid this cycle.
REQ-008 flush  input  1  synchronous discard of partial word and stall state; clears overflow.
REQ-009 word_ready  input  1  consumer accepts word_out when high with word_valid.
REQ-010 word_out  output  8*WORD_BYTES  assembled word, registered.
REQ-011 word_valid  output  1  word_out holds an unconsumed word.
REQ-012 fill_level  output  clog2(WORD_BYTES)+1  bytes currently held in packer.
REQ-013 overflow  output  1  sticky; a byte was dropped.
REQ-014 word_count  output  16  words delivered (handshakes completed), wraps at 0xFFFF->0.

Function
REQ-015 Byte acceptance: reg_enable alone selects reg_data; wire_enable alone selects wire_data; one byte per cycle maximum.
REQ-016 Both enables high: reg_data accepted, wire_data dropped, overflow set.
REQ-017 Packing is little-endian: first accepted byte -> word_out[7:0], byte k -> bits [8k+7:8k].
REQ-018 States: COLLECT (fill_level < WORD_BYTES) and STALL (full word held, output register occupied).
REQ-019 COLLECT: accepted byte increments fill_level; when it completes the word and output is free (word_valid=0, or word_valid=1 and word_ready=1 this cycle), the word loads into word_out next edge, word_valid=1, fill_level=0.
REQ-020 Latency: last byte sampled at edge N -> word_valid high after edge N (visible in cycle N+1).
REQ-021 COLLECT: word completes while output is not free -> go to STALL, fill_level=WORD_BYTES.
REQ-022 STALL: any input byte dropped, overflow set; when output frees (word_ready=1), held word transfers to word_out at that edge, fill_level=0, back to COLLECT.
REQ-023 Handshake: transfer on word_valid & word_ready at the edge; word_valid falls unless a new word loads on the same edge; word_out stable while word_valid=1 and word_ready=0.
REQ-024 word_count increments by 1 on each completed handshake.
REQ-025 flush: fill_level=0, state=COLLECT, overflow=0 next edge; a same-cycle input byte is discarded without setting overflow; word_out/word_valid/word_count unaffected; a same-cycle handshake still completes.
REQ-026 Enables low: no state change except handshake effects.

Reset
REQ-027 Reset asserts asynchronously: word_out=0, word_valid=0, fill_level=0, overflow=0, word_count=0, state=COLLECT.
REQ-028 Reset mid-word or mid-STALL discards all held bytes; first byte after deassertion starts a new word at bits [7:0].
REQ-029 Inputs ignored while reset is high.

Structure
REQ-030 Shared package test_traditional_pkg holds: state enum (COLLECT, STALL), default WORD_BYTES constant, byte width constant 8, word_count width 16.
REQ-031 Single module; no sub-module required. The lane select/collision logic is a local function, not a separate instance.

Verification
REQ-032 reg_enable bytes 0x11,0x22,0x33,0x44 on consecutive cycles, word_ready=1 -> word_out=0x44332211, word_valid for 1 cycle, word_count=1.
REQ-033 Both enables high with reg_data=0xAA, wire_data=0xBB -> byte 0xAA packed, overflow=1, fill_level increments by 1.
REQ-034 word_ready=0, two full words sent (0x04030201, 0x08070605), then byte 0x09 -> second word in STALL, 0x09 dropped, overflow=1; raise word_ready -> 0x04030201 then 0x08070605 delivered in order, word_count=2.
REQ-035 Two bytes 0x01,0x02 then flush with wire_enable byte 0x03 in same cycle -> fill_level=0, overflow=0; next 4 bytes 0x05..0x08 yield 0x08070605.
REQ-036 Reset asserted asynchronously mid-cycle with fill_level=3 and word_valid=1 -> all outputs zero immediately, without waiting for a clock edge.
REQ-037 word_count preset to 0xFFFF via 65535 handshakes (or forced), one more handshake -> word_count=0x0000.
